// File: rtl/fsm_job_arbiter.sv
// fsm_job_arbiter: shares one start/flag_done sequencing engine among N_REQ
// requesters. Round-robin arbitration with one job in flight. The arbiter
// issues a one-cycle engine start, waits for flag_done or a timeout, and then
// returns a done or err pulse to the owning requester.
//
// Handshake summary: a requester raises req and keeps it high until it sees
// its done or err pulse. The owner sees grant from the ISSUE cycle through the
// RELEASE cycle. eng_start is high for exactly one cycle per job.
// eng_flag_done is only looked at while the job is in WAIT. Every output comes
// straight from a register or from a decode of the state register, so there is
// no combinational path from any input to any output.
module fsm_job_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 16,
    parameter int ID_W    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             hold,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id,
    output logic [N_REQ-1:0] done,
    output logic [N_REQ-1:0] err,
    output logic             busy,
    output logic             eng_start,
    input  logic             eng_flag_done,
    output logic [1:0]       dbg_state
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_ARB     = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [ID_W-1:0]    grant_id_q, grant_id_d;
    logic [ID_W-1:0]    last_id_q, last_id_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic [N_REQ-1:0]   err_q, err_d;

    // Round-robin pick signals.
    logic [N_REQ-1:0]   hi_mask;
    logic [N_REQ-1:0]   masked_req;
    logic [N_REQ-1:0]   cand_req;
    logic [ID_W-1:0]    pick_id;
    logic [N_REQ-1:0]   pick_onehot;

    // Round-robin pick: prefer the lowest request strictly above last_id.
    // If there is none, wrap to the lowest request overall.
    always_comb begin
        hi_mask     = '0;
        pick_id     = '0;
        pick_onehot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            hi_mask[i] = (i > int'(last_id_q));
        end
        masked_req = req & hi_mask;
        cand_req   = (|masked_req) ? masked_req : req;
        // Scan downwards so that the lowest set index is the one left standing.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (cand_req[i]) begin
                pick_id = ID_W'(i);
            end
        end
        pick_onehot[pick_id] = |cand_req;
    end

    // Next-state and next-register computation for the job sequencer.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        last_id_d  = last_id_q;
        cnt_d      = cnt_q;
        done_d     = '0;
        err_d      = '0;
        case (state_q)
            S_ARB: begin
                if (!hold && (|req)) begin
                    grant_d    = pick_onehot;
                    grant_id_d = pick_id;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Completion beats a timeout that lands in the same cycle.
                if (eng_flag_done) begin
                    done_d  = grant_q;
                    state_d = S_RELEASE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d   = grant_q;
                    state_d = S_RELEASE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RELEASE: begin
                // grant stays up through this cycle, which covers the engine's
                // DONE cycle. It drops on the way back to ARB.
                grant_d   = '0;
                last_id_d = grant_id_q;
                state_d   = S_ARB;
            end
            default: begin
                grant_d = '0;
                state_d = S_ARB;
            end
        endcase
    end

    // State register. An asynchronous reset aborts any job silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_ARB;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: owner, last owner, WAIT counter and completion pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q    <= '0;
            grant_id_q <= '0;
            // Point at the top index so that requester 0 has highest priority.
            last_id_q  <= ID_W'(N_REQ - 1);
            cnt_q      <= '0;
            done_q     <= '0;
            err_q      <= '0;
        end else begin
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            last_id_q  <= last_id_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign grant     = grant_q;
    assign grant_id  = grant_id_q;
    assign done      = done_q;
    assign err       = err_q;
    assign busy      = (state_q != S_ARB);
    assign eng_start = (state_q == S_ISSUE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fsm_job_arbiter.sv
// Bench for fsm_job_arbiter. A behavioural engine responds to eng_start.
// A job-level reference model predicts the winner, the job length and the
// outcome, and the bench checks every output on every cycle of each job.
module tb_fsm_job_arbiter;
    localparam int N  = 4;
    localparam int TO = 16;
    localparam int IW = 2;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  req;
    logic          hold;
    logic [N-1:0]  grant;
    logic [IW-1:0] grant_id;
    logic [N-1:0]  done;
    logic [N-1:0]  err;
    logic          busy;
    logic          eng_start;
    logic          eng_flag_done;
    logic [1:0]    dbg_state;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: who owned the last job, and which requests are pending.
    int            last_m;
    logic [N-1:0]  pend;

    // Engine model controls. Modes used by run_job:
    //   mode 0 = engine enabled; flag_done follows eng_start two cycles later
    //   mode 1 = engine disabled; flag_done is forced on a chosen WAIT cycle
    //   mode 2 = engine disabled; no flag_done at all, so the job times out
    logic          eng_en;
    logic          force_flag;
    logic [1:0]    eng_sh;

    fsm_job_arbiter #(.N_REQ(N), .TIMEOUT(TO), .ID_W(IW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req           (req),
        .hold          (hold),
        .grant         (grant),
        .grant_id      (grant_id),
        .done          (done),
        .err           (err),
        .busy          (busy),
        .eng_start     (eng_start),
        .eng_flag_done (eng_flag_done),
        .dbg_state     (dbg_state)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Engine model: IDLE -> LOAD -> EXEC. flag_done is raised in EXEC,
    // two cycles after the start pulse.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) eng_sh <= '0;
        else        eng_sh <= {eng_sh[0], eng_start & eng_en};
    end
    assign eng_flag_done = eng_sh[1] | force_flag;

    // Watchdog so that the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Spec rule: first set request at or after (last+1) mod N, wrapping around.
    function automatic int rr_pick(input logic [N-1:0] r, input int last);
        for (int i = 1; i <= N; i++) begin
            int j;
            j = (last + i) % N;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, ".grant"},     grant,     '0);
        chk({tag, ".busy"},      busy,      1'b0);
        chk({tag, ".eng_start"}, eng_start, 1'b0);
        chk({tag, ".done"},      done,      '0);
        chk({tag, ".err"},       err,       '0);
    endtask

    // Hold the arbiter off for n cycles with requests pending. Optionally
    // inject a spurious flag_done while nothing is in flight.
    task automatic idle_hold(input int n, input bit spurious);
        hold = 1'b1;
        req  = pend;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk_idle("hold_idle");
            force_flag = spurious && (k == 0);
        end
        force_flag = 1'b0;
    endtask

    // Entry and exit both happen at a negedge while the DUT is in ARB.
    task automatic run_job(input int mode, input int flag_cyc, input bit hold_mid, input bit drop_mid);
        int w;
        int len;
        logic [N-1:0] oh;
        w = rr_pick(pend, last_m);
        if (w < 0) begin
            chk("job_nonempty", 32'd0, 32'd1);
            return;
        end
        oh = '0;
        oh[w] = 1'b1;
        len = (mode == 0) ? 4 : (mode == 1) ? flag_cyc + 1 : TO + 2;
        eng_en     = (mode == 0);
        force_flag = 1'b0;
        req        = pend;
        hold       = 1'b0;
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            chk("grant",     grant,     oh);
            chk("grant_id",  grant_id,  w);
            chk("busy",      busy,      1'b1);
            chk("eng_start", eng_start, (k == 1));
            chk("done",      done,      (k == len && mode != 2) ? oh : '0);
            chk("err",       err,       (k == len && mode == 2) ? oh : '0);
            force_flag = (mode == 1) && (k == flag_cyc);
            if (hold_mid && k == 2) hold = 1'b1;
            if (drop_mid && k == 2) req[w] = 1'b0;
            if (k == len) hold = 1'b0;
        end
        force_flag = 1'b0;
        pend[w]    = 1'b0;
        req        = pend;
        last_m     = w;
        @(negedge clk);
        chk_idle("after_job");
    endtask

    initial begin
        rst_n      = 1'b0;
        req        = '0;
        hold       = 1'b0;
        eng_en     = 1'b1;
        force_flag = 1'b0;
        pend       = '0;
        last_m     = N - 1;

        // Reset state.
        repeat (2) @(negedge clk);
        chk_idle("reset");
        chk("reset.grant_id", grant_id, '0);
        rst_n = 1'b1;

        // Single requester with a well-behaved engine.
        pend = 4'b0001;
        run_job(0, 0, 1'b0, 1'b0);

        // All four requesting continuously: round-robin order.
        for (int j = 0; j < 5; j++) begin
            pend = 4'b1111;
            run_job(0, 0, 1'b0, 1'b0);
        end
        pend = '0;
        req  = '0;

        // Engine never answers: timeout, then the next requester is served.
        pend = 4'b0011;
        run_job(2, 0, 1'b0, 1'b0);
        run_job(0, 0, 1'b0, 1'b0);

        // Hold blocks new grants; a spurious flag in ARB changes nothing.
        pend = 4'b0100;
        idle_hold(4, 1'b1);
        run_job(0, 0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of WAIT.
        pend   = 4'b0010;
        req    = pend;
        eng_en = 1'b1;
        hold   = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst.grant",     grant,     '0);
        chk("async_rst.busy",      busy,      1'b0);
        chk("async_rst.eng_start", eng_start, 1'b0);
        req = '0;
        @(negedge clk);
        chk_idle("in_reset");
        rst_n  = 1'b1;
        last_m = N - 1;
        pend   = 4'b0011;
        run_job(0, 0, 1'b0, 1'b0);
        run_job(0, 0, 1'b0, 1'b0);

        // flag_done on the final timeout cycle: done wins over err.
        pend = 4'b1000;
        run_job(1, TO + 1, 1'b0, 1'b0);

        // Randomised jobs.
        for (int j = 0; j < 40; j++) begin
            int mode;
            int r;
            pend = pend | N'($urandom_range(1, (1 << N) - 1));
            r    = $urandom_range(0, 9);
            mode = (r < 6) ? 0 : (r < 8) ? 1 : 2;
            if ($urandom_range(0, 4) == 0) idle_hold($urandom_range(1, 3), $urandom_range(0, 1));
            run_job(mode, $urandom_range(2, TO + 1), $urandom_range(0, 1), $urandom_range(0, 2) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
